// File: rtl/tdm_voice_sequencer_pkg.sv
// Shared constants and FSM encoding for the TDM voice sequencer.
package tdm_pkg;

  localparam int unsigned NUM_VOICES_DEF = 4;

  localparam logic WAVE_SAW    = 1'b0;
  localparam logic WAVE_SQUARE = 1'b1;

  localparam logic [15:0] FIX15_MAX = 16'h7FFF;

  localparam int unsigned IDLE_CHAN = NUM_VOICES_DEF - 1;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/tdm_voice_sequencer_if.sv
// Voice configuration valid/ready channel.
interface tdm_voice_sequencer_if #(
  parameter int unsigned CHANBITS = 2,
  parameter int unsigned PHASE_W  = 24
);

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CHANBITS-1:0] cfg_voice;
  logic                cfg_gate;
  logic                cfg_wave;
  logic [PHASE_W-1:0]  cfg_inc;

  modport master (
    output cfg_valid,
    output cfg_voice,
    output cfg_gate,
    output cfg_wave,
    output cfg_inc,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_voice,
    input  cfg_gate,
    input  cfg_wave,
    input  cfg_inc,
    output cfg_ready
  );

endinterface

// File: rtl/tdm_voice_sequencer_wave_shaper.sv
// Combinational phase-to-sample map: sawtooth from the phase MSBs, or a square wave.
module tdm_wave_shaper
  import tdm_pkg::*;
#(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned D_W     = 16
) (
  input  logic [PHASE_W-1:0] phase,
  input  logic               wave,
  output logic [D_W-1:0]     sample
);

  always_comb begin
    sample = '0;
    if (wave == WAVE_SQUARE) begin
      sample = phase[PHASE_W-1] ? D_W'(FIX15_MAX) : '0;
    end else begin
      sample = {1'b0, phase[PHASE_W-1 -: D_W-1]};
    end
  end

endmodule

// File: rtl/tdm_voice_sequencer.sv
// Sample-rate TDM source: on each tick, emits one registered slot per voice and advances
// that voice's phase accumulator.
module tdm_voice_sequencer
  import tdm_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned CHANBITS   = 2,
  parameter int unsigned D_W        = 16,
  parameter int unsigned PHASE_W    = 24
) (
  input  logic                   dsp_clk,
  input  logic                   dsp_rst_n,
  input  logic                   sample_tick,
  tdm_voice_sequencer_if.slave   cfg,
  output logic [CHANBITS-1:0]    channel_out,
  output logic                   is_channel_enabled,
  output logic [D_W-1:0]         data_out_fix15_u16,
  output logic                   busy,
  output logic                   tick_overrun
);

  localparam logic [CHANBITS-1:0] LastSlot = CHANBITS'(NUM_VOICES - 1);

  state_e              state_q;
  logic [CHANBITS-1:0] slot_q;

  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] inc_q   [NUM_VOICES];
  logic               gate_q  [NUM_VOICES];
  logic               wave_q  [NUM_VOICES];

  logic                cfg_fire;
  logic                emit;
  logic [CHANBITS-1:0] emit_idx;
  logic                fwd;
  logic                eff_gate;
  logic                eff_wave;
  logic [PHASE_W-1:0]  eff_inc;
  logic [PHASE_W-1:0]  eff_phase;
  logic [D_W-1:0]      shaped;

  assign cfg.cfg_ready = (state_q == StIdle);
  assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;
  assign busy          = (state_q == StRun);

  // slot_q names the slot currently on the outputs; the next edge loads emit_idx.
  always_comb begin
    emit     = 1'b0;
    emit_idx = '0;
    if (state_q == StIdle) begin
      emit = sample_tick;
    end else if (slot_q != LastSlot) begin
      emit     = 1'b1;
      emit_idx = slot_q + 1'b1;
    end
  end

  // Slot 0 can be emitted on the same edge a config lands, so forward the new values.
  always_comb begin
    fwd       = cfg_fire && (cfg.cfg_voice == emit_idx);
    eff_gate  = fwd ? cfg.cfg_gate : gate_q[emit_idx];
    eff_wave  = fwd ? cfg.cfg_wave : wave_q[emit_idx];
    eff_inc   = fwd ? cfg.cfg_inc  : inc_q[emit_idx];
    eff_phase = (fwd && cfg.cfg_gate) ? '0 : phase_q[emit_idx];
  end

  tdm_wave_shaper #(
    .PHASE_W (PHASE_W),
    .D_W     (D_W)
  ) u_shaper (
    .phase  (eff_phase),
    .wave   (eff_wave),
    .sample (shaped)
  );

  always_ff @(posedge dsp_clk) begin
    if (!dsp_rst_n) begin
      state_q            <= StIdle;
      slot_q             <= '0;
      channel_out        <= LastSlot;
      is_channel_enabled <= 1'b0;
      data_out_fix15_u16 <= '0;
      tick_overrun       <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
        gate_q[i]  <= 1'b0;
        wave_q[i]  <= 1'b0;
      end
    end else begin
      if (cfg_fire) begin
        inc_q[cfg.cfg_voice]  <= cfg.cfg_inc;
        gate_q[cfg.cfg_voice] <= cfg.cfg_gate;
        wave_q[cfg.cfg_voice] <= cfg.cfg_wave;
        if (cfg.cfg_gate) begin
          phase_q[cfg.cfg_voice] <= '0;
        end
      end

      // Placed after the config write so a same-voice update overrides it.
      if (emit) begin
        phase_q[emit_idx]  <= eff_gate ? eff_phase + eff_inc : eff_phase;
        slot_q             <= emit_idx;
        channel_out        <= emit_idx;
        is_channel_enabled <= eff_gate;
        data_out_fix15_u16 <= eff_gate ? shaped : '0;
      end

      unique case (state_q)
        StIdle: begin
          if (sample_tick) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (sample_tick) begin
            tick_overrun <= 1'b1;
          end
          if (slot_q == LastSlot) begin
            state_q            <= StIdle;
            channel_out        <= LastSlot;
            is_channel_enabled <= 1'b0;
            data_out_fix15_u16 <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_voice_sequencer.sv
// Scoreboard bench for tdm_voice_sequencer: stimulus queues expected slots, a negedge
// monitor pops and compares them while busy and checks idle outputs otherwise.
module tb_tdm_voice_sequencer;
  import tdm_pkg::*;

  localparam int unsigned NUM_VOICES = 4;
  localparam int unsigned CHANBITS   = 2;
  localparam int unsigned D_W        = 16;
  localparam int unsigned PHASE_W    = 24;

  logic                dsp_clk = 1'b0;
  logic                dsp_rst_n = 1'b0;
  logic                sample_tick = 1'b0;
  logic [CHANBITS-1:0] channel_out;
  logic                is_channel_enabled;
  logic [D_W-1:0]      data_out_fix15_u16;
  logic                busy;
  logic                tick_overrun;

  tdm_voice_sequencer_if #(.CHANBITS(CHANBITS), .PHASE_W(PHASE_W)) cfg_bus ();

  tdm_voice_sequencer #(
    .NUM_VOICES (NUM_VOICES),
    .CHANBITS   (CHANBITS),
    .D_W        (D_W),
    .PHASE_W    (PHASE_W)
  ) dut (
    .dsp_clk            (dsp_clk),
    .dsp_rst_n          (dsp_rst_n),
    .sample_tick        (sample_tick),
    .cfg                (cfg_bus),
    .channel_out        (channel_out),
    .is_channel_enabled (is_channel_enabled),
    .data_out_fix15_u16 (data_out_fix15_u16),
    .busy               (busy),
    .tick_overrun       (tick_overrun)
  );

  always #5 dsp_clk = ~dsp_clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic        en;
    logic [15:0] data;
  } slot_t;

  slot_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  always @(negedge dsp_clk) begin
    if (mon_en) begin
      slot_t act;
      slot_t exp;
      act = {channel_out, is_channel_enabled, data_out_fix15_u16};
      if (busy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_slot: got 0x%0h, required no slot", act);
        end else begin
          exp = exp_q.pop_front();
          check("slot", 32'(act), 32'(exp));
        end
      end else begin
        check("idle_outputs", 32'(act), 32'({2'd3, 1'b0, 16'h0000}));
      end
    end
  end

  task automatic step();
    @(posedge dsp_clk);
    #1;
  endtask

  task automatic push_sweep(input logic [3:0] en, input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3);
    exp_q.push_back({2'd0, en[0], d0});
    exp_q.push_back({2'd1, en[1], d1});
    exp_q.push_back({2'd2, en[2], d2});
    exp_q.push_back({2'd3, en[3], d3});
  endtask

  task automatic do_tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    repeat (7) step();
  endtask

  task automatic do_cfg(input logic [1:0] voice, input logic gate, input logic wave,
                        input logic [23:0] inc);
    int k;
    cfg_bus.cfg_voice = voice;
    cfg_bus.cfg_gate  = gate;
    cfg_bus.cfg_wave  = wave;
    cfg_bus.cfg_inc   = inc;
    cfg_bus.cfg_valid = 1'b1;
    k = 0;
    while (!cfg_bus.cfg_ready && k < 50) begin
      step();
      k++;
    end
    if (k == 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL cfg_timeout: got cfg_ready=0 for 50 cycles, required 1");
    end
    step();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  logic [15:0] v0_saw [5] = '{16'h1000, 16'h1800, 16'h2000, 16'h2800, 16'h3000};
  logic [15:0] v2_sq  [5] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000};

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_voice = '0;
    cfg_bus.cfg_gate  = 1'b0;
    cfg_bus.cfg_wave  = 1'b0;
    cfg_bus.cfg_inc   = '0;

    repeat (3) step();
    mon_en    = 1'b1;
    dsp_rst_n = 1'b1;

    // Reset / idle hold
    repeat (20) begin
      check("idle_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      step();
    end

    // Voice 0 sawtooth
    do_cfg(2'd0, 1'b1, WAVE_SAW, 24'h100000);
    push_sweep(4'b0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    do_tick();
    push_sweep(4'b0001, 16'h0800, 16'h0000, 16'h0000, 16'h0000);
    do_tick();

    // Voice 2 square, period of four sweeps
    do_cfg(2'd2, 1'b1, WAVE_SQUARE, 24'h400000);
    for (int s = 0; s < 5; s++) begin
      push_sweep(4'b0101, v0_saw[s], 16'h0000, v2_sq[s], 16'h0000);
      do_tick();
    end
    check("overrun_clear", 32'(tick_overrun), 32'd0);

    // Ticks at T, T+4 (overrun) and T+5 (accepted)
    push_sweep(4'b0101, 16'h3800, 16'h0000, 16'h0000, 16'h0000);
    push_sweep(4'b0101, 16'h4000, 16'h0000, 16'h7FFF, 16'h0000);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    repeat (3) step();
    sample_tick = 1'b1;
    repeat (2) step();
    sample_tick = 1'b0;
    repeat (6) step();
    check("overrun_set", 32'(tick_overrun), 32'd1);

    // Config held through a sweep, accepted together with the next tick
    push_sweep(4'b0101, 16'h4800, 16'h0000, 16'h7FFF, 16'h0000);
    push_sweep(4'b0111, 16'h5000, 16'h0000, 16'h0000, 16'h0000);
    sample_tick = 1'b1;
    step();
    sample_tick       = 1'b0;
    cfg_bus.cfg_voice = 2'd1;
    cfg_bus.cfg_gate  = 1'b1;
    cfg_bus.cfg_wave  = WAVE_SAW;
    cfg_bus.cfg_inc   = 24'h080000;
    cfg_bus.cfg_valid = 1'b1;
    repeat (4) begin
      check("run_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd0);
      step();
    end
    check("post_sweep_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    sample_tick = 1'b1;
    step();
    sample_tick       = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    repeat (6) step();

    // Reset during slot 2
    exp_q.push_back({2'd0, 1'b1, 16'h5800});
    exp_q.push_back({2'd1, 1'b1, 16'h0400});
    exp_q.push_back({2'd2, 1'b1, 16'h0000});
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    dsp_rst_n = 1'b0;
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outputs", 32'({channel_out, is_channel_enabled, data_out_fix15_u16}),
          32'({2'd3, 1'b0, 16'h0000}));
    repeat (2) step();
    dsp_rst_n = 1'b1;
    check("rst_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check("rst_overrun", 32'(tick_overrun), 32'd0);

    // Post-reset: all voices off, then a fresh voice starts at phase 0
    push_sweep(4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    do_tick();
    do_cfg(2'd0, 1'b1, WAVE_SAW, 24'h100000);
    push_sweep(4'b0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    do_tick();
    push_sweep(4'b0001, 16'h0800, 16'h0000, 16'h0000, 16'h0000);
    do_tick();

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
